// File: rtl/imm_pkg.sv
// Shared immediate-extraction types and helper for the decode stage.
// IMM_GEN_ZIMM_EN enables the CSR zimm type (110); otherwise 110 decodes as illegal.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_JALR = 3'b101,
        IMM_ZIMM = 3'b110
    } imm_src_e;

    // Skid buffer occupancy, encoded as {main_v, skid_v}.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

    localparam int IMM_FIELD_MSB = 31;
    localparam int IMM_MAX_W     = 64;

    typedef struct packed {
        logic                 illegal;
        logic [IMM_MAX_W-1:0] imm;
    } imm_res_t;

    // Extends to the widest XLEN; narrower users truncate, which keeps the sign replication correct.
    function automatic imm_res_t imm_extract(input logic [IMM_FIELD_MSB:7] instr,
                                             input imm_src_e               src);
        imm_res_t res;
        res.illegal = 1'b0;
        res.imm     = '0;
        case (src)
            IMM_I, IMM_JALR: res.imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:           res.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:           res.imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:           res.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:           res.imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            IMM_ZIMM:        res.imm = {59'b0, instr[19:15]};
`endif
            default:         res.illegal = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer: main register drives the outputs, skid register absorbs one extra entry.
// Handshake: a side transfers when valid && ready in the same cycle; in_ready is registered (!skid_v).
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state;
    logic [W-1:0] main_d;
    logic [W-1:0] skid_d;
    logic         rdy_q;
    logic         accept;
    logic         pop;

    assign out_valid = state[1];
    assign out_data  = main_d;
    assign in_ready  = rdy_q;
    assign accept    = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;

    // rdy_q resets low and rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BUF_EMPTY;
            main_d <= '0;
            skid_d <= '0;
            rdy_q  <= 1'b0;
        end else if (flush) begin
            state <= BUF_EMPTY;
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= 1'b1;
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_d <= in_data;
                        state  <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && !pop) begin
                        skid_d <= in_data;
                        state  <= BUF_FULL;
                        rdy_q  <= 1'b0;
                    end else if (accept && pop) begin
                        main_d <= in_data;
                    end else if (pop) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        main_d <= skid_d;
                        state  <= BUF_ONE;
                    end else begin
                        rdy_q <= 1'b0;
                    end
                end
                default: state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational extraction feeding a 2-entry skid buffer.
// Define IMM_GEN_ZIMM_EN to accept type 110 (CSR zimm); otherwise it is flagged illegal.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int PW = 1 + XLEN + TAG_W;

    imm_res_t        res;
    logic [XLEN-1:0] imm_x;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   out_payload;

    assign res        = imm_extract(in_instr, imm_src_e'(in_imm_src));
    assign imm_x      = XLEN'(res.imm);
    assign in_payload = {res.illegal, imm_x, in_tag};

    imm_skid_buf #(.W(PW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_illegal, out_imm, out_tag} = out_payload;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=64; IMM_GEN_ZIMM_EN selects the expected zimm result.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [TAG_W-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_imm_src  (in_imm_src),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [TAG_W-1:0] tag);
        in_instr   = instr[31:7];
        in_imm_src = src;
        in_tag     = tag;
        in_valid   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_imm_src = '0; in_tag = '0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_imm !== '0 || out_tag !== '0 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b imm=%h tag=%h ill=%b, expected all 0",
                     out_valid, out_imm, out_tag, out_illegal);
        end
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_single(input string name, input logic [31:0] instr, input logic [2:0] src,
                               input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_imm,
                               input logic exp_ill);
        out_ready = 1'b1;
        drive(instr, src, tag);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b expected 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_valid_latency: got %b expected 1", name, out_valid);
        end
        n_checks++;
        if (out_imm !== exp_imm) begin
            n_fail++;
            $display("FAIL %s out_imm: got %h expected %h", name, out_imm, exp_imm);
        end
        n_checks++;
        if (out_illegal !== exp_ill || out_tag !== tag) begin
            n_fail++;
            $display("FAIL %s ill/tag: got %b/%h expected %b/%h", name, out_illegal, out_tag, exp_ill, tag);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain: got out_valid %b expected 0", name, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int next_tag = 1;
        int popped   = 0;
        int cnt      = 0;
        logic acc, pop, stall_prev;
        logic [XLEN-1:0]  prev_imm;
        logic [TAG_W-1:0] prev_tag;
        logic [31:0]      w;
        stall_prev = 1'b0;
        prev_imm = '0;
        prev_tag = '0;
        exp_q.delete();
        for (int c = 0; c < 60 && popped < 6; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (next_tag <= 6) begin
                w = {12'(next_tag), 20'h00093};
                drive(w, 3'b000, TAG_W'(next_tag));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in_ready !== (cnt < 2)) begin
                n_fail++;
                $display("FAIL b2b_in_ready c=%0d: got %b expected %b", c, in_ready, (cnt < 2));
            end
            n_checks++;
            if (out_valid !== (cnt > 0)) begin
                n_fail++;
                $display("FAIL b2b_out_valid c=%0d: got %b expected %b", c, out_valid, (cnt > 0));
            end
            if (stall_prev) begin
                n_checks++;
                if (out_tag !== prev_tag || out_imm !== prev_imm) begin
                    n_fail++;
                    $display("FAIL b2b_stall_stable c=%0d: got %h/%h expected %h/%h",
                             c, out_tag, out_imm, prev_tag, prev_imm);
                end
            end
            pop = (cnt > 0) && out_ready;
            acc = in_valid && (cnt < 2);
            if (pop) begin
                n_checks++;
                if (out_tag !== exp_q[0] || out_imm !== XLEN'(exp_q[0])) begin
                    n_fail++;
                    $display("FAIL b2b_order c=%0d: got tag %h imm %h expected %h",
                             c, out_tag, out_imm, exp_q[0]);
                end
                void'(exp_q.pop_front());
                popped++;
            end
            if (acc) begin
                exp_q.push_back(TAG_W'(next_tag));
                next_tag++;
            end
            stall_prev = (cnt > 0) && !out_ready;
            prev_tag = out_tag;
            prev_imm = out_imm;
            cnt = cnt + int'(acc) - int'(pop);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (popped != 6) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d entries out expected 6", popped);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'b000, 32'd10);
        tick();
        drive(32'hFFF00093, 3'b000, 32'd11);
        tick();
        drive(32'hFFF00093, 3'b000, 32'd12);
        flush = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full_precond: got in_ready %b expected 0", in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        drive(32'hFFF00093, 3'b000, 32'd20);
        tick();
        drive(32'hFFF00093, 3'b000, 32'd21);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drops_input: got out_valid %b expected 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'b000, 32'd30);
        tick();
        drive(32'hFFF00093, 3'b111, 32'd31);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_tag !== 32'd30) begin
            n_fail++;
            $display("FAIL reset_mid_precond: got v=%b tag=%h expected 1/0000001e", out_valid, out_tag);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_imm !== '0 || out_tag !== '0 || out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got v=%b imm=%h tag=%h ill=%b expected all 0",
                     out_valid, out_imm, out_tag, out_illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single("i_type",  32'hFFF00093, 3'b000, 32'hA1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        test_single("s_type",  32'hFE20AE23, 3'b001, 32'hA2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        test_single("b_type",  32'hFE000EE3, 3'b010, 32'hA3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        test_single("u_type",  32'h123450B7, 3'b011, 32'hA4, 64'h0000_0000_1234_5000, 1'b0);
        test_single("j_pos",   32'h001000EF, 3'b100, 32'hA5, 64'h0000_0000_0000_0800, 1'b0);
        test_single("j_neg",   32'h8000006F, 3'b100, 32'hA6, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
        test_single("jalr",    32'h7FF00067, 3'b101, 32'hA7, 64'h0000_0000_0000_07FF, 1'b0);
        test_single("illegal", 32'hFFFFFFFF, 3'b111, 32'hA8, 64'h0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
        test_single("zimm",    32'h000F5073, 3'b110, 32'hA9, 64'h0000_0000_0000_001E, 1'b0);
`else
        test_single("zimm",    32'h000F5073, 3'b110, 32'hA9, 64'h0, 1'b1);
`endif
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
